// File: rtl/icache_pkg.sv
// Shared types and helpers for the direct-mapped instruction cache.
//   icache_state_t : refill FSM state
//   NOP            : instruction returned whenever instrF is not a real hit
//   *_bits()       : address field widths derived from the cache geometry
package icache_pkg;

  typedef enum logic {IDLE = 1'b0, REFILL = 1'b1} icache_state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic int off_bits(input int wpl);
    return $clog2(wpl);
  endfunction

  function automatic int idx_bits(input int lines);
    return $clog2(lines);
  endfunction

  // Tag covers whatever decoded address bits remain above byte/word/index.
  function automatic int tag_bits(input int wad, input int lines, input int wpl);
    return wad - 2 - $clog2(wpl) - $clog2(lines);
  endfunction

endpackage

// File: rtl/icache_line_store.sv
// Tag and data arrays of the cache. Combinational read, synchronous write.
//   rd_idx_i/rd_woff_i -> rd_tag_o/rd_word_o : lookup port
//   wr_idx_i/wr_woff_i/wr_data_i, word_we_i  : refill word write
//   wr_tag_i, tag_we_i                       : tag write for wr_idx_i
// Arrays are intentionally not reset; validity lives in the top module.
module icache_line_store #(
  parameter int W     = 32,
  parameter int LINES = 16,
  parameter int WPL   = 4,
  parameter int TB    = 8
) (
  input  logic                     clk,
  input  logic [$clog2(LINES)-1:0] rd_idx_i,
  input  logic [$clog2(WPL)-1:0]   rd_woff_i,
  output logic [TB-1:0]            rd_tag_o,
  output logic [W-1:0]             rd_word_o,
  input  logic [$clog2(LINES)-1:0] wr_idx_i,
  input  logic [$clog2(WPL)-1:0]   wr_woff_i,
  input  logic [W-1:0]             wr_data_i,
  input  logic                     word_we_i,
  input  logic [TB-1:0]            wr_tag_i,
  input  logic                     tag_we_i
);

  logic [TB-1:0] tag_q  [LINES];
  logic [W-1:0]  data_q [LINES][WPL];

  always_ff @(posedge clk) begin
    if (word_we_i) data_q[wr_idx_i][wr_woff_i] <= wr_data_i;
    if (tag_we_i)  tag_q[wr_idx_i]             <= wr_tag_i;
  end

  assign rd_tag_o  = tag_q[rd_idx_i];
  assign rd_word_o = data_q[rd_idx_i][rd_woff_i];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache for the fetch stage.
//   pcF/reqF        : fetch address and request
//   flushF          : invalidate all lines (fence.i)
//   instrF/stallF   : same-cycle hit data / fetch hold
//   misalignF       : request with pcF[1:0] != 0 (ignored otherwise)
//   memReq/memAddr  : refill word request to backing memory
//   memRdata/memValid : refill word return
//   hitCount/missCount : wrapping performance counters
module icache_dm
  import icache_pkg::*;
#(
  parameter int W     = 32,
  parameter int WAD   = 16,
  parameter int LINES = 16,
  parameter int WPL   = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [W-1:0]   pcF,
  input  logic           reqF,
  input  logic           flushF,
  output logic [W-1:0]   instrF,
  output logic           stallF,
  output logic           misalignF,
  output logic           memReq,
  output logic [WAD-1:0] memAddr,
  input  logic [W-1:0]   memRdata,
  input  logic           memValid,
  output logic [31:0]    hitCount,
  output logic [31:0]    missCount
);

  localparam int OB = off_bits(WPL);
  localparam int IB = idx_bits(LINES);
  localparam int TB = tag_bits(WAD, LINES, WPL);
  localparam int MB = TB + IB;

  icache_state_t    state_q, state_d;
  logic [LINES-1:0] valid_q, valid_d;
  logic [MB-1:0]    missAddr_q, missAddr_d;
  logic [OB-1:0]    wcnt_q, wcnt_d;
  logic             flushPend_q, flushPend_d;
  logic [31:0]      hitCount_q, hitCount_d, missCount_q, missCount_d;

  logic [IB-1:0] pc_idx, ms_idx;
  logic [TB-1:0] pc_tag, ms_tag, rd_tag;
  logic [OB-1:0] pc_woff;
  logic [W-1:0]  rd_word;
  logic          lookup, hit, beat, last;
  logic          unused_pc;

  assign pc_woff = pcF[2 +: OB];
  assign pc_idx  = pcF[2+OB +: IB];
  assign pc_tag  = pcF[2+OB+IB +: TB];
  assign ms_idx  = missAddr_q[IB-1:0];
  assign ms_tag  = missAddr_q[MB-1:IB];
  assign unused_pc = ^{pcF[W-1:WAD]};

  icache_line_store #(.W(W), .LINES(LINES), .WPL(WPL), .TB(TB)) u_store (
    .clk       (clk),
    .rd_idx_i  (pc_idx),
    .rd_woff_i (pc_woff),
    .rd_tag_o  (rd_tag),
    .rd_word_o (rd_word),
    .wr_idx_i  (ms_idx),
    .wr_woff_i (wcnt_q),
    .wr_data_i (memRdata),
    .word_we_i (beat),
    .wr_tag_i  (ms_tag),
    .tag_we_i  (last)
  );

  assign misalignF = reqF & (pcF[1:0] != 2'b00);
  assign lookup    = reqF & ~misalignF;
  assign hit       = (state_q == IDLE) & valid_q[pc_idx] & (rd_tag == pc_tag);
  assign beat      = (state_q == REFILL) & memValid;
  assign last      = beat & (wcnt_q == OB'(WPL - 1));

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    missAddr_d  = missAddr_q;
    wcnt_d      = wcnt_q;
    flushPend_d = flushPend_q;
    hitCount_d  = hitCount_q;
    missCount_d = missCount_q;
    case (state_q)
      IDLE: begin
        flushPend_d = 1'b0;
        if (lookup) begin
          if (hit) begin
            hitCount_d = hitCount_q + 32'd1;
          end else begin
            missCount_d = missCount_q + 32'd1;
            missAddr_d  = pcF[WAD-1:2+OB];
            wcnt_d      = '0;
            state_d     = REFILL;
          end
        end
      end
      REFILL: begin
        if (beat) wcnt_d = wcnt_q + 1'b1;
        if (last) begin
          state_d     = IDLE;
          flushPend_d = 1'b0;
          // A flush seen earlier in this refill leaves the line invalid.
          if (!flushPend_q) valid_d[ms_idx] = 1'b1;
        end else if (flushF) begin
          flushPend_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Flush wins over a same-cycle final beat.
    if (flushF) valid_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      missAddr_q  <= '0;
      wcnt_q      <= '0;
      flushPend_q <= 1'b0;
      hitCount_q  <= '0;
      missCount_q <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      missAddr_q  <= missAddr_d;
      wcnt_q      <= wcnt_d;
      flushPend_q <= flushPend_d;
      hitCount_q  <= hitCount_d;
      missCount_q <= missCount_d;
    end
  end

  assign memReq    = (state_q == REFILL);
  assign memAddr   = {missAddr_q, wcnt_q, 2'b00};
  assign stallF    = lookup & ((state_q == REFILL) | ~hit);
  assign instrF    = (lookup & hit) ? rd_word : W'(NOP);
  assign hitCount  = hitCount_q;
  assign missCount = missCount_q;

endmodule

// File: doc/icache_dm.md
# icache_dm

Direct-mapped, parametrised instruction cache that replaces the flat combinational instruction ROM in the fetch stage. On a hit it returns `instrF` in the same cycle from `pcF`, like the ROM it replaces. On a miss it stalls fetch and refills one line word-by-word from a backing instruction memory over a valid handshake. It adds line invalidation (flush, for `fence.i`), misalignment detection and hit/miss performance counters.

## Interface
Parameters:
- `W`, 32: data and PC width.
- `WAD`, 16: byte-address bits decoded; `pcF[W-1:WAD]` is ignored.
- `LINES`, 16: number of cache lines; power of two, ≥2.
- `WPL`, 4: 32-bit words per line; power of two, ≥2.

Ports:
- `clk`  in  1: single clock, all state on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `pcF`  in  W: fetch byte address.
- `reqF`  in  1: fetch request valid.
- `flushF`  in  1: invalidate all lines (one-cycle pulse).
- `instrF`  out  W: fetched instruction.
- `stallF`  out  1: fetch must hold `pcF`; `instrF` is not valid.
- `misalignF`  out  1: `reqF & (pcF[1:0] != 0)`.
- `memReq`  out  1: refill word request.
- `memAddr`  out  WAD: byte address of the requested word, word-aligned.
- `memRdata`  in  W: returned word.
- `memValid`  in  1: `memRdata` is valid for the current `memAddr`.
- `hitCount`, `missCount`  out  32: performance counters.

## Operation
- Address split, from LSB to MSB: byte offset 2 bits, word offset log2(WPL) bits, index log2(LINES) bits, tag = the remaining `WAD` bits.
- Storage per line: a valid bit, a tag and WPL data words.
- `hit = valid[idx] & (tag[idx] == pcF tag)` while in state IDLE.
- State machine `{IDLE, REFILL}`:
  - IDLE, `reqF & ~misalignF & ~hit`: latch the line base address (tag and index) into `missAddr`, clear `wcnt`, go to REFILL, increment `missCount`.
  - IDLE, `reqF & ~misalignF & hit`: increment `hitCount`; no state change.
  - REFILL: hold `memReq = 1` and `memAddr = {missAddr, wcnt, 2'b00}`. On each cycle with `memValid`, write `memRdata` into word `wcnt` and increment `wcnt`.
  - REFILL, `memValid` with `wcnt == WPL-1`: write the tag, set the valid bit (unless a flush occurred during this refill), go to IDLE.
- Outputs:
  - `stallF = reqF & ~misalignF & (state == REFILL | ~hit)`.
  - `instrF` = the hit word when `reqF & hit & ~misalignF` and the state is IDLE; otherwise 32'h00000013 (NOP).
- Misaligned request: no lookup, no refill, no counter update, `stallF = 0`, `instrF` = NOP, `misalignF = 1`.
- `flushF`: clears every valid bit at the next edge. During REFILL it also sets `flushPend`. The refill still completes, but the line is left invalid. `flushPend` clears on the return to IDLE.
- `pcF` may change during REFILL. The refill always completes for `missAddr`; after the return to IDLE, the current `pcF` is looked up again.
- Counters wrap modulo 2^32.

## Timing
- Hit: combinational, zero-cycle latency from `pcF` to `instrF`.
- Miss penalty: 1 cycle (IDLE→REFILL) plus WPL `memValid` beats, plus 1 lookup cycle that hits. With `memValid` tied high, a miss costs WPL+1 stall cycles.
- `memValid` may arrive in the same cycle `memReq` and `memAddr` are presented, or any number of cycles later. `memAddr` stays stable until `memValid`.
- Reset values: state IDLE, all valid bits 0, `wcnt` 0, `flushPend` 0, `memReq` 0, counters 0. Data and tag arrays are not reset.
- During reset, outputs are `stallF = reqF & ~misalignF` and `instrF` = NOP.
- Reset asserted mid-refill: `memReq` drops asynchronously and the partial line is discarded (left invalid).
- `flushF` in the same cycle as a miss in IDLE: the flush takes effect, the refill starts, and the refilled line becomes valid.
- A `memValid` beat in the same cycle as `flushF` during REFILL: the word is written, and the line ends invalid.

## Structure
- Package `icache_pkg` holds:
  - state enum `icache_state_t {IDLE, REFILL}`;
  - `localparam NOP = 32'h00000013`;
  - field-width helper functions for offset, index and tag bits.
- Sub-module `icache_line_store` holds the data and tag arrays: combinational read, synchronous write, with separate tag-write and word-write enables. Valid bits, the FSM and the counters stay in the top module.

## Test plan
- Cold fetch at `pcF` = 0x0000, `memValid` always 1, memory word n = 0x1000+n: `stallF` high for 5 cycles (WPL=4). Next cycle `instrF` = 0x00001000 with `stallF` = 0; `missCount` = 1, `hitCount` = 1.
- Sequential fetch 0x0004, 0x0008, 0x000C after the line fill: all hit in consecutive cycles, with `instrF` = 0x1001, 0x1002, 0x1003.
- Conflict: fetch 0x0000, then 0x0100 (same index, tag+1 with default parameters), then 0x0000: three misses, `missCount` = 3, and the correct data is returned each time.
- `memValid` every third cycle: `memAddr` steps 0x40, 0x44, 0x48, 0x4C, each held until its beat; stall lasts 13 cycles.
- `flushF` pulsed on the second refill beat: the refill completes, and the following lookup of the same address misses again.
- `pcF` = 0x0002: `misalignF` = 1, `instrF` = 0x00000013, `stallF` = 0, counters unchanged.
- `rst_n` asserted mid-refill: `memReq` falls immediately. After release, the same address misses.
